// File: rtl/demux_scheduler.sv
// Round-robin word scheduler driving a 1:8 demux: accepts one word, grants a ready lane,
// delivers it for one cycle, then idles for GUARD_CYCLES. Optional word counter: DEMUX_SCHED_CNT_EN.
module demux_scheduler #(
    parameter int unsigned GUARD_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [3:0]  datain,
    output logic        in_ready,
    input  logic [7:0]  lane_ready,
    output logic [2:0]  select,
    output logic [3:0]  dataout,
    output logic        out_valid
`ifdef DEMUX_SCHED_CNT_EN
    ,
    output logic [15:0] word_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, ARB, DRIVE, GUARD} state_t;

    localparam logic [3:0] GUARD_LOAD = (GUARD_CYCLES == 0) ? 4'd0 : 4'(GUARD_CYCLES - 1);

    state_t     state, state_nxt;
    logic [2:0] ptr;
    logic [2:0] grant;
    logic [2:0] idx;
    logic       grant_vld;
    logic [3:0] hold;
    logic [3:0] guard_cnt;

    assign in_ready = (state == IDLE) && !rst;

    // First ready lane at or after ptr, wrapping modulo 8.
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        idx       = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            idx = ptr + 3'(i);
            if (!grant_vld && lane_ready[idx]) begin
                grant     = idx;
                grant_vld = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = ARB;
            ARB:     if (grant_vld) state_nxt = DRIVE;
            DRIVE:   state_nxt = (GUARD_CYCLES > 0) ? GUARD : IDLE;
            GUARD:   if (guard_cnt == '0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are loaded on ARB->DRIVE so they are valid for exactly the DRIVE cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            select    <= '0;
            dataout   <= '0;
            out_valid <= 1'b0;
            hold      <= '0;
            guard_cnt <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (in_valid) hold <= datain;
                end
                ARB: begin
                    if (grant_vld) begin
                        select    <= grant;
                        dataout   <= hold;
                        out_valid <= 1'b1;
                    end
                end
                DRIVE: begin
                    out_valid <= 1'b0;
                    dataout   <= '0;
                    ptr       <= select + 3'd1;
                    guard_cnt <= GUARD_LOAD;
                end
                GUARD: begin
                    if (guard_cnt != '0) guard_cnt <= guard_cnt - 4'd1;
                end
                default: ;
            endcase
        end
    end

`ifdef DEMUX_SCHED_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_cnt <= '0;
        end else if (state == DRIVE) begin
            word_cnt <= word_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_demux_scheduler.sv
// Directed bench for demux_scheduler: per-cycle comparison against a transaction-level
// model plus literal expectations for latency, round-robin order, stalls and reset.
module tb_demux_scheduler;

    localparam int unsigned GC = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [3:0]  datain = '0;
    logic        in_ready;
    logic [7:0]  lane_ready = '0;
    logic [2:0]  select;
    logic [3:0]  dataout;
    logic        out_valid;
`ifdef DEMUX_SCHED_CNT_EN
    logic [15:0] word_cnt;
`endif

    int checks = 0;
    int failures = 0;
    logic cmp_en = 1'b0;

    always #5 clk = ~clk;

    demux_scheduler #(.GUARD_CYCLES(GC)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .datain     (datain),
        .in_ready   (in_ready),
        .lane_ready (lane_ready),
        .select     (select),
        .dataout    (dataout),
        .out_valid  (out_valid)
`ifdef DEMUX_SCHED_CNT_EN
        ,
        .word_cnt   (word_cnt)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: a word is either absent, waiting for a lane, being delivered, or in guard time.
    logic       m_busy, m_wait, m_dlv;
    int         m_guard, m_ptr;
    logic [2:0] m_sel;
    logic [3:0] m_word;

    function automatic int rr_pick(input logic [7:0] lr, input int p);
        for (int i = 0; i < 8; i++)
            if (lr[(p + i) % 8]) return (p + i) % 8;
        return -1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0; m_wait <= 1'b0; m_dlv <= 1'b0;
            m_guard <= 0; m_ptr <= 0; m_sel <= '0; m_word <= '0;
        end else if (m_dlv) begin
            m_dlv <= 1'b0;
            m_ptr <= (int'(m_sel) + 1) % 8;
            if (GC > 0) m_guard <= GC;
            else        m_busy  <= 1'b0;
        end else if (m_guard > 0) begin
            m_guard <= m_guard - 1;
            if (m_guard == 1) m_busy <= 1'b0;
        end else if (m_wait) begin
            if (lane_ready != 8'h00) begin
                m_sel  <= 3'(rr_pick(lane_ready, m_ptr));
                m_dlv  <= 1'b1;
                m_wait <= 1'b0;
            end
        end else if (!m_busy && in_valid) begin
            m_busy <= 1'b1; m_wait <= 1'b1; m_word <= datain;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc_in_ready",  32'(in_ready),  32'(!rst && !m_busy));
            chk("cyc_out_valid", 32'(out_valid), 32'(m_dlv));
            chk("cyc_dataout",   32'(dataout),   32'(m_dlv ? m_word : 4'h0));
            chk("cyc_select",    32'(select),    32'(m_sel));
        end
    end

    task automatic do_reset();
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_select",    32'(select),    32'd0);
        chk("rst_dataout",   32'(dataout),   32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        @(posedge clk); #2;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_release_in_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic hs(input logic [3:0] w);
        int n = 0;
        while (!in_ready && n < 40) begin @(posedge clk); #1; n++; end
        chk("hs_ready_timeout", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        datain   = w;
        @(posedge clk); #1;
        in_valid = 1'b0;
        datain   = '0;
    endtask

    task automatic xfer(input logic [3:0] w, input logic [7:0] lr, input logic [2:0] esel);
        int n = 0;
        lane_ready = lr;
        hs(w);
        while (!out_valid && n < 40) begin @(posedge clk); #1; n++; end
        chk("xfer_out_valid", 32'(out_valid), 32'd1);
        chk("xfer_select",    32'(select),    32'(esel));
        chk("xfer_dataout",   32'(dataout),   32'(w));
    endtask

    initial begin
        #1 rst = 1'b1;
        #1 cmp_en = 1'b1;
        #20 rst = 1'b0;
        @(posedge clk); #1;

        // Latency with all lanes ready.
        lane_ready = 8'hFF;
        hs(4'hA);
        chk("lat_n1_out_valid", 32'(out_valid), 32'd0);
        chk("lat_n1_in_ready",  32'(in_ready),  32'd0);
        @(posedge clk); #1;
        chk("lat_n2_out_valid", 32'(out_valid), 32'd1);
        chk("lat_n2_select",    32'(select),    32'd0);
        chk("lat_n2_dataout",   32'(dataout),   32'hA);
        @(posedge clk); #1;
        chk("lat_n3_in_ready",  32'(in_ready),  32'd0);
        chk("lat_n3_dataout",   32'(dataout),   32'd0);
        @(posedge clk); #1;
        chk("lat_n4_in_ready",  32'(in_ready),  32'd1);

        // Round-robin through all eight lanes, then wrap.
        do_reset();
        for (int i = 0; i < 8; i++) xfer(4'(i + 1), 8'hFF, 3'(i));
        xfer(4'h9, 8'hFF, 3'd0);

        // Pointer at 3 with sparse lanes.
        do_reset();
        for (int i = 0; i < 3; i++) xfer(4'h1, 8'hFF, 3'(i));
        xfer(4'hB, 8'b0010_0001, 3'd5);
        xfer(4'hD, 8'b0010_0001, 3'd0);

        // Grant is fixed once made; lane_ready dropping during DRIVE has no effect.
        lane_ready = 8'h10;
        hs(4'hE);
        @(posedge clk); #1;
        lane_ready = 8'h00;
        chk("drive_hold_out_valid", 32'(out_valid), 32'd1);
        chk("drive_hold_select",    32'(select),    32'd4);
        chk("drive_hold_dataout",   32'(dataout),   32'hE);

        // Indefinite stall with no lane ready.
        lane_ready = 8'h00;
        hs(4'h6);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("stall_out_valid", 32'(out_valid), 32'd0);
            chk("stall_in_ready",  32'(in_ready),  32'd0);
        end
        lane_ready = 8'h04;
        @(posedge clk); #1;
        chk("stall_release_out_valid", 32'(out_valid), 32'd1);
        chk("stall_release_select",    32'(select),    32'd2);
        chk("stall_release_dataout",   32'(dataout),   32'h6);

        // Reset during ARB discards the held word.
        do_reset();
        xfer(4'h3, 8'hFF, 3'd0);
        lane_ready = 8'h00;
        hs(4'hC);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("arb_rst_out_valid", 32'(out_valid), 32'd0);
        chk("arb_rst_select",    32'(select),    32'd0);
        @(posedge clk); #2;
        rst = 1'b0;
        lane_ready = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        chk("arb_rst_no_delivery", 32'(out_valid), 32'd0);
        xfer(4'h5, 8'hFF, 3'd0);

`ifdef DEMUX_SCHED_CNT_EN
        do_reset();
        for (int i = 0; i < 3; i++) xfer(4'h7, 8'hFF, 3'(i));
        repeat (4) @(posedge clk);
        #1;
        chk("word_cnt_three", 32'(word_cnt), 32'd3);
        force dut.word_cnt = 16'hFFFF;
        @(posedge clk); #1;
        release dut.word_cnt;
        xfer(4'h8, 8'hFF, 3'd3);
        @(posedge clk); #1;
        chk("word_cnt_wrap", 32'(word_cnt), 32'd0);
`endif

        repeat (4) @(posedge clk);
        #1;
        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/demux_scheduler.md
DEMUX_SCHEDULER -- requirements
Module: demux_scheduler

Interface
REQ-001 Parameter GUARD_CYCLES, default 1, meaning idle cycles between deliveries with select held and dataout zero; legal range 0..15.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  1  upstream word available on datain.
REQ-005 datain  input  4  upstream data word.
REQ-006 in_ready  output  1  block can accept a word this cycle.
REQ-007 lane_ready  input  8  bit k high means downstream lane k (demux output k+1) can take a word.
REQ-008 select  output  3  registered lane select driving the 1:8 demux.
REQ-009 dataout  output  4  registered data driving the demux input; zero except while delivering.
REQ-010 out_valid  output  1  one-cycle strobe, high while dataout carries a word.
REQ-011 word_cnt  output  16  delivered-word count; present only when DEMUX_SCHED_CNT_EN is defined.

Function
REQ-012 The FSM SHALL have four states: IDLE, ARB, DRIVE, GUARD.
REQ-013 IDLE: in_ready=1; on in_valid=1, capture datain into hold register and go to ARB; otherwise stay.
REQ-014 in_ready SHALL be 1 only in IDLE; in_valid outside IDLE is ignored and upstream holds the word.
REQ-015 ARB: search lane_ready round-robin from pointer ptr (ptr, ptr+1, ... mod 8); first set bit k wins, select<=k, go to DRIVE.
REQ-016 ARB with lane_ready=8'h00 SHALL remain in ARB, keep the held word, out_valid=0, with no timeout.
REQ-017 DRIVE: out_valid=1 and dataout=held word for exactly one cycle; ptr<=k+1 mod 8, so lane 7 wraps to 0.
REQ-018 lane_ready changes during DRIVE SHALL NOT affect the delivery; the grant is fixed in ARB.
REQ-019 After DRIVE: go to GUARD if GUARD_CYCLES>0, else go to IDLE.
REQ-020 GUARD: out_valid=0 and dataout=0 with select unchanged, for exactly GUARD_CYCLES cycles (4-bit counter), then IDLE.
REQ-021 Latency: handshake at edge N, ARB samples lane_ready in cycle N+1, out_valid is high in cycle N+2 if a lane is ready.
REQ-022 Throughput: at most one word per 3+GUARD_CYCLES cycles.
REQ-023 select SHALL change only on the ARB->DRIVE transition.
REQ-024 dataout SHALL be 4'h0 in every state except DRIVE.

Reset
REQ-025 Asserting rst SHALL immediately force: state=IDLE, ptr=0, select=0, dataout=0, out_valid=0, hold=0, guard counter=0, word_cnt=0.
REQ-026 in_ready SHALL be 0 while rst is high and 1 from the first cycle after deassertion.
REQ-027 rst in ARB, DRIVE or GUARD SHALL discard the held word with no partial delivery; out_valid drops the same cycle.

Configuration
REQ-028 With macro DEMUX_SCHED_CNT_EN defined, word_cnt SHALL increment by 1 on each DRIVE cycle and wrap 16'hFFFF->16'h0000.
REQ-029 Without DEMUX_SCHED_CNT_EN, the word_cnt port and counter logic SHALL be absent; all other behaviour is identical.

Verification
REQ-030 Reset then in_valid=1, datain=4'hA, lane_ready=8'hFF, GUARD_CYCLES=1 -> out_valid in cycle N+2, select=0, dataout=4'hA; in_ready high again in cycle N+4.
REQ-031 Eight back-to-back words 4'h1..4'h8, lane_ready=8'hFF -> select sequence 0,1,...,7, ninth word 4'h9 -> select=0 (wrap).
REQ-032 ptr=3, lane_ready=8'b0010_0001 -> select=5; next word with the same lane_ready -> select=0.
REQ-033 lane_ready=8'h00 for 10 cycles after accepting 4'h6, then lane_ready=8'h04 -> out_valid=0 and in_ready=0 throughout the wait, then out_valid with select=2, dataout=4'h6.
REQ-034 rst pulsed during ARB holding 4'hC -> no out_valid, select=0, and the next word delivered goes to lane 0.
REQ-035 With DEMUX_SCHED_CNT_EN defined, 3 deliveries -> word_cnt=3; counter preset to 16'hFFFF, then one delivery -> word_cnt=16'h0000.
